// File: rtl/tx_channel_arbiter.sv
// Round-robin arbiter sharing one tx interpolation chain among NUM_CHAN FIFO readers.
// Holds the grant for a whole burst, gates pkt_waiting/tx_strobe and muxes sample data.
module tx_channel_arbiter #(
    parameter int unsigned  CHAN_W   = 2,
    parameter logic [15:0]  TIMEOUT  = 16'd1024,
    localparam int unsigned NUM_CHAN = 2**CHAN_W
) (
    input  logic                     tx_clock,
    input  logic                     reset,
    input  logic                     tx_strobe,
    input  logic [NUM_CHAN-1:0]      chan_req,
    input  logic [NUM_CHAN-1:0]      chan_burst,
    input  logic [NUM_CHAN-1:0]      chan_tx_empty,
    input  logic [16*NUM_CHAN-1:0]   chan_tx_i,
    input  logic [16*NUM_CHAN-1:0]   chan_tx_q,
    output logic [NUM_CHAN-1:0]      chan_pkt_waiting,
    output logic [NUM_CHAN-1:0]      chan_strobe,
    output logic [15:0]              tx_i,
    output logic [15:0]              tx_q,
    output logic                     tx_empty,
    output logic                     grant_valid,
    output logic [CHAN_W-1:0]        grant_chan,
    output logic [7:0]               timeout_count
);

    typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [CHAN_W-1:0] last_chan, last_chan_nxt;
    logic [CHAN_W-1:0] grant_chan_nxt;
    logic [CHAN_W-1:0] cand, pick;
    logic [15:0]       strobe_cnt, strobe_cnt_nxt, cnt_inc;
    logic              forced, forced_nxt;
    logic [7:0]        timeout_count_nxt;
    logic              found, hit_timeout, g_burst, g_empty, gate;

    assign grant_valid = (state != IDLE);
    assign gate        = grant_valid && (state != RELEASE);

    always_ff @(posedge tx_clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_chan     <= '1;
            grant_chan    <= '0;
            strobe_cnt    <= '0;
            forced        <= 1'b0;
            timeout_count <= '0;
        end else begin
            state         <= state_nxt;
            last_chan     <= last_chan_nxt;
            grant_chan    <= grant_chan_nxt;
            strobe_cnt    <= strobe_cnt_nxt;
            forced        <= forced_nxt;
            timeout_count <= timeout_count_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        last_chan_nxt     = last_chan;
        grant_chan_nxt    = grant_chan;
        strobe_cnt_nxt    = strobe_cnt;
        forced_nxt        = forced;
        timeout_count_nxt = timeout_count;
        found             = 1'b0;
        pick              = '0;
        cand              = '0;
        cnt_inc           = (strobe_cnt == 16'hFFFF) ? strobe_cnt : strobe_cnt + 16'd1;
        hit_timeout       = (TIMEOUT != 16'd0) && (cnt_inc >= TIMEOUT);
        g_burst           = chan_burst[grant_chan];
        g_empty           = chan_tx_empty[grant_chan];

        // Scan starts just past the last served channel; i == NUM_CHAN wraps onto it.
        for (int unsigned i = 1; i <= NUM_CHAN; i++) begin
            cand = last_chan + CHAN_W'(i);
            if (!found && chan_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    grant_chan_nxt = pick;
                    strobe_cnt_nxt = '0;
                    forced_nxt     = 1'b0;
                    state_nxt      = GRANT;
                end
            end
            GRANT: begin
                if (g_burst || !g_empty) begin
                    strobe_cnt_nxt = '0;
                    state_nxt      = ACTIVE;
                end else if (tx_strobe) begin
                    strobe_cnt_nxt = cnt_inc;
                    if (hit_timeout) begin
                        forced_nxt = 1'b1;
                        state_nxt  = RELEASE;
                    end
                end
            end
            ACTIVE: begin
                if (tx_strobe) begin
                    if (!g_burst && g_empty) begin
                        state_nxt = RELEASE;
                    end else if (g_empty) begin
                        strobe_cnt_nxt = cnt_inc;
                        if (hit_timeout) begin
                            forced_nxt = 1'b1;
                            state_nxt  = RELEASE;
                        end
                    end else begin
                        strobe_cnt_nxt = '0;
                    end
                end
            end
            RELEASE: begin
                last_chan_nxt = grant_chan;
                if (forced && (timeout_count != 8'hFF))
                    timeout_count_nxt = timeout_count + 8'd1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        chan_pkt_waiting = '0;
        chan_strobe      = '0;
        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
            if (gate && (grant_chan == CHAN_W'(c))) begin
                chan_pkt_waiting[c] = chan_req[c];
                chan_strobe[c]      = tx_strobe;
            end
        end
    end

    always_ff @(posedge tx_clock or negedge reset) begin
        if (!reset) begin
            tx_i     <= '0;
            tx_q     <= '0;
            tx_empty <= 1'b1;
        end else if (grant_valid) begin
            tx_i     <= chan_tx_i[{grant_chan, 4'b0000} +: 16];
            tx_q     <= chan_tx_q[{grant_chan, 4'b0000} +: 16];
            tx_empty <= chan_tx_empty[grant_chan];
        end else begin
            tx_i     <= '0;
            tx_q     <= '0;
            tx_empty <= 1'b1;
        end
    end

endmodule

// File: doc/tx_channel_arbiter.md
# tx_channel_arbiter

Shares the single tx chain among NUM_CHAN channel FIFO readers. Grants one channel at a time, round-robin, and gates that channel's pkt_waiting and tx_strobe. Holds the grant for the channel's whole burst, muxes its tx_i/tx_q/tx_empty onto the chain, and forcibly releases a channel that stalls. Sits between the per-channel FIFO readers and the tx interpolation chain, in the tx_clock domain.

## Interface
Parameters:
- CHAN_W, 2, channel index width; NUM_CHAN = 2**CHAN_W
- TIMEOUT, 16'd1024, tx_strobe count before forced release; 0 disables timeout

Ports:
- tx_clock  in  1  sole clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- tx_strobe  in  1  tx chain sample request
- chan_req  in  NUM_CHAN  per-channel pkt_waiting from the channel FIFOs
- chan_burst  in  NUM_CHAN  per-reader burst flag
- chan_tx_empty  in  NUM_CHAN  per-reader tx_empty
- chan_tx_i  in  16*NUM_CHAN  reader tx_i, channel c at [16c+15:16c]
- chan_tx_q  in  16*NUM_CHAN  reader tx_q, same packing
- chan_pkt_waiting  out  NUM_CHAN  gated pkt_waiting to readers, combinational
- chan_strobe  out  NUM_CHAN  gated tx_strobe to readers, combinational
- tx_i  out  16  muxed I to tx chain, registered
- tx_q  out  16  muxed Q to tx chain, registered
- tx_empty  out  1  muxed empty to tx chain, registered
- grant_valid  out  1  a channel holds the grant
- grant_chan  out  CHAN_W  granted channel index
- timeout_count  out  8  saturating count of forced releases

## Operation
States: IDLE, GRANT, ACTIVE, RELEASE. Internal: last_chan (CHAN_W), strobe_cnt (16 bits).
- IDLE: grant_valid=0. If any chan_req bit is set, select the first set bit scanning last_chan+1, last_chan+2, … modulo NUM_CHAN. Register it into grant_chan, clear strobe_cnt, go to GRANT.
- GRANT: grant_valid=1.
  - chan_burst[g]=1 or chan_tx_empty[g]=0 → ACTIVE, strobe_cnt cleared.
  - Otherwise each tx_strobe increments strobe_cnt. strobe_cnt reaching TIMEOUT (TIMEOUT≠0) → RELEASE as a forced release.
- ACTIVE: grant_valid=1. On a tx_strobe cycle:
  - chan_burst[g]=0 and chan_tx_empty[g]=1 → RELEASE (normal).
  - chan_tx_empty[g]=1 with chan_burst[g]=1 increments strobe_cnt. Reaching TIMEOUT → RELEASE (forced, underrunning burst).
  - chan_tx_empty[g]=0 clears strobe_cnt.
- RELEASE: grant_valid=1 for this single cycle. last_chan<=grant_chan. On a forced release, timeout_count increments and saturates at 255. Then → IDLE.
- chan_pkt_waiting[c] = chan_req[c] & grant_valid & (grant_chan==c) & state≠RELEASE.
- chan_strobe[c] = tx_strobe & grant_valid & (grant_chan==c) & state≠RELEASE.
- Outputs when a channel is granted: tx_i/tx_q/tx_empty <= chan_tx_i/q/empty of grant_chan every cycle.
- Outputs otherwise: 0/0/1.
- Arithmetic: round-robin index wraps modulo NUM_CHAN. strobe_cnt saturates at 16'hFFFF.

## Timing
- Reset (reset=0, async): state=IDLE, last_chan=NUM_CHAN-1 (so channel 0 has first priority), strobe_cnt=0, timeout_count=0, tx_i=0, tx_q=0, tx_empty=1, grant_valid=0, grant_chan=0. Combinational outputs are 0.
- Reset asserted mid-burst: all gating drops immediately and the grant is lost. The reader is expected to be reset by the same signal.
- Request to grant: chan_req seen in IDLE at cycle n gives grant_valid=1 and the gated pkt_waiting from cycle n+1.
- Data path: tx_i/tx_q/tx_empty lag reader outputs by 1 cycle.
- Strobe gating has zero latency: reader and chain see the same tx_strobe edge.
- Release to next grant: a minimum of 2 cycles (RELEASE, then IDLE) with no channel enabled.
- Simultaneous requests: only round-robin order decides.
- A request arriving during RELEASE is evaluated in the following IDLE cycle.
- A channel dropping chan_req while in GRANT does not release early. Only the timeout releases it.

## Test plan
- Reset: hold reset=0 with random inputs → tx_empty=1, tx_i=tx_q=0, grant_valid=0, all chan_strobe=0. Release reset with chan_req=4'b0001 → grant_chan=0 two cycles later.
- Round-robin: chan_req=4'b1111 held, each granted burst of 3 samples then burst=0/empty=1 → grant order 0,1,2,3,0 with grant gap of exactly 2 cycles.
- Strobe gating: grant ch2, tx_strobe every 4 cycles → chan_strobe=4'b0100 on exactly those cycles, others 0. tx_i equals chan_tx_i[47:32] one cycle later.
- Idle timeout: TIMEOUT=8, grant ch1 that never bursts → release after 8th strobe, timeout_count=1, next requester granted.
- Underrun timeout: ch3 burst=1, tx_empty=1 for 8 strobes → forced release, timeout_count increments. Counter saturates at 255 after 300 forced releases.
- Mid-burst reset: assert reset during ACTIVE → outputs to reset values within the same cycle (async). After release, grant restarts from channel 0.
